// File: rtl/std_gray_count_receiver.sv
// Purpose: reader end of a Gray-coded counter crossing into this clock domain; decodes it to binary and reports the step delta.
// Latency: SYNC_STAGES edges from i_gray to o_gray, then one more edge to o_count/o_delta/o_changed/o_error.
// Backpressure: none; a new sample is taken every cycle. Optional checker: define STD_GRAY_COUNT_RECEIVER_CHECK_EN.
module std_gray_count_receiver #(
    parameter int                 WIDTH         = 2,
    parameter int                 SYNC_STAGES   = 2,
    parameter logic [WIDTH-1:0]   INITIAL_COUNT = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clear,
    input  logic [WIDTH-1:0] i_gray,
    output logic [WIDTH-1:0] o_gray,
    output logic [WIDTH-1:0] o_count,
    output logic [WIDTH-1:0] o_delta,
    output logic             o_changed,
    output logic             o_error
);

    // Gray form of the reset count, so the chain and o_count agree after reset
    localparam logic [WIDTH-1:0] INIT_GRAY = INITIAL_COUNT ^ (INITIAL_COUNT >> 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] dec_bin;
    logic [WIDTH-1:0] delta_nxt;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] delta_q;
    logic             changed_q;

    // Synchronizer chain: first stage takes the asynchronous input, later stages shift it along
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= INIT_GRAY;
            end
        end else begin
            sync_q[0] <= i_gray;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign o_gray = sync_q[SYNC_STAGES-1];

    // Gray to binary: each binary bit is the XOR of all Gray bits at and above it
    always_comb begin
        dec_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dec_bin[i] = ^(o_gray >> i);
        end
    end

    // Modulo-2^WIDTH difference handles wrap-around in both directions
    assign delta_nxt = dec_bin - count_q;

    // Registered count, delta and change pulse; clear realigns without reporting a step
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q   <= INITIAL_COUNT;
            delta_q   <= '0;
            changed_q <= 1'b0;
        end else if (i_clear) begin
            count_q   <= dec_bin;
            delta_q   <= '0;
            changed_q <= 1'b0;
        end else begin
            count_q   <= dec_bin;
            delta_q   <= delta_nxt;
            changed_q <= (delta_nxt != '0);
        end
    end

    assign o_count   = count_q;
    assign o_delta   = delta_q;
    assign o_changed = changed_q;

`ifdef STD_GRAY_COUNT_RECEIVER_CHECK_EN
    logic [WIDTH-1:0] prev_gray_q;
    logic [WIDTH-1:0] gray_diff;
    logic             multi_bit;
    logic             error_q;

    // More than one bit set in the diff means the remote side skipped a Gray step
    assign gray_diff = o_gray ^ prev_gray_q;
    assign multi_bit = (gray_diff & (gray_diff - WIDTH'(1))) != '0;

    // Previous synchronized sample and the registered error pulse
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            prev_gray_q <= INIT_GRAY;
            error_q     <= 1'b0;
        end else begin
            prev_gray_q <= o_gray;
            error_q     <= i_clear ? 1'b0 : multi_bit;
        end
    end

    assign o_error = error_q;
`else
    assign o_error = 1'b0;
`endif

endmodule

// File: tb/tb_std_gray_count_receiver.sv
module tb_std_gray_count_receiver;

`ifdef STD_GRAY_COUNT_RECEIVER_CHECK_EN
    localparam bit CE = 1'b1;
`else
    localparam bit CE = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       clr;
    logic [3:0] gray;
    logic [3:0] o_gray;
    logic [3:0] o_count;
    logic [3:0] o_delta;
    logic       o_changed;
    logic       o_error;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] og;
        logic [3:0] cnt;
        logic [3:0] dl;
        logic       ch;
        logic       er;
    } exp_t;

    exp_t exp_q[$];

    // Gray code for binary 0..15
    logic [3:0] gtab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                              4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

    std_gray_count_receiver #(
        .WIDTH(4),
        .SYNC_STAGES(2),
        .INITIAL_COUNT(4'd0)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_clear   (clr),
        .i_gray    (gray),
        .o_gray    (o_gray),
        .o_count   (o_count),
        .o_delta   (o_delta),
        .o_changed (o_changed),
        .o_error   (o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int vec, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d actual=%h expected=%h", name, vec, act, exp);
        end
    endtask

    // Drive one vector on the falling edge and queue the outputs expected after the next rising edge
    task automatic v(input logic r, input logic c, input logic [3:0] g,
                     input logic [3:0] og, input logic [3:0] cnt, input logic [3:0] dl,
                     input logic ch, input logic er);
        exp_t e;
        @(negedge clk);
        rst  = r;
        clr  = c;
        gray = g;
        e.og = og; e.cnt = cnt; e.dl = dl; e.ch = ch; e.er = er;
        exp_q.push_back(e);
    endtask

    // Monitor: outputs are presented every cycle; compare each against the queued expectation
    initial begin
        exp_t e;
        int   n = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("o_gray",    n, o_gray,          e.og);
                chk("o_count",   n, o_count,         e.cnt);
                chk("o_delta",   n, o_delta,         e.dl);
                chk("o_changed", n, {3'b0, o_changed}, {3'b0, e.ch});
                chk("o_error",   n, {3'b0, o_error},   {3'b0, e.er});
                n++;
            end
        end
    end

    initial begin
        int b;
        rst = 1'b1; clr = 1'b0; gray = 4'b1111;

        // 1: reset with all-ones input, then first cycle after release
        repeat (3) v(1, 0, 4'b1111, 4'h0, 4'h0, 4'h0, 0, 0);
        v(0, 0, 4'b0000, 4'h0, 4'h0, 4'h0, 0, 0);
        v(0, 0, 4'b0000, 4'h0, 4'h0, 4'h0, 0, 0);

        // 2: single step 0 -> 1
        v(0, 0, 4'b0001, 4'h0, 4'h0, 4'h0, 0, 0);
        v(0, 0, 4'b0001, 4'h1, 4'h0, 4'h0, 0, 0);
        v(0, 0, 4'b0001, 4'h1, 4'h1, 4'h1, 1, 0);
        v(0, 0, 4'b0001, 4'h1, 4'h1, 4'h0, 0, 0);

        // 3: walk bin 2..15 then wrap to 0, one step per 4 cycles
        for (int s = 2; s <= 16; s++) begin
            b = s % 16;
            v(0, 0, gtab[b], gtab[s-1], 4'(s-1), 4'h0, 0, 0);
            v(0, 0, gtab[b], gtab[b],   4'(s-1), 4'h0, 0, 0);
            v(0, 0, gtab[b], gtab[b],   4'(b),   4'h1, 1, 0);
            v(0, 0, gtab[b], gtab[b],   4'(b),   4'h0, 0, 0);
        end

        // 4: illegal two-bit jump 0000 -> 0011 (bin 2)
        v(0, 0, 4'b0011, 4'b0000, 4'h0, 4'h0, 0, 0);
        v(0, 0, 4'b0011, 4'b0011, 4'h0, 4'h0, 0, 0);
        v(0, 0, 4'b0011, 4'b0011, 4'h2, 4'h2, 1, CE);
        v(0, 0, 4'b0011, 4'b0011, 4'h2, 4'h0, 0, 0);

        // 5: clear realigns to bin 4 (Gray 0110) with no delta, change or error pulse
        v(1, 0, 4'b0000, 4'h0, 4'h0, 4'h0, 0, 0);
        v(0, 0, 4'b0110, 4'h0, 4'h0, 4'h0, 0, 0);
        v(0, 0, 4'b0110, 4'b0110, 4'h0, 4'h0, 0, 0);
        v(0, 1, 4'b0110, 4'b0110, 4'h4, 4'h0, 0, 0);
        v(0, 0, 4'b0110, 4'b0110, 4'h4, 4'h0, 0, 0);
        v(0, 0, 4'b0110, 4'b0110, 4'h4, 4'h0, 0, 0);

        // 6: reset while a step is in flight, then the held sample arrives after release
        v(1, 0, 4'b0000, 4'h0, 4'h0, 4'h0, 0, 0);
        v(0, 0, 4'b0000, 4'h0, 4'h0, 4'h0, 0, 0);
        v(0, 0, 4'b0001, 4'h0, 4'h0, 4'h0, 0, 0);
        v(1, 0, 4'b0001, 4'h0, 4'h0, 4'h0, 0, 0);
        v(0, 0, 4'b0001, 4'h0, 4'h0, 4'h0, 0, 0);
        v(0, 0, 4'b0001, 4'h1, 4'h0, 4'h0, 0, 0);
        v(0, 0, 4'b0001, 4'h1, 4'h1, 4'h1, 1, 0);
        v(0, 0, 4'b0001, 4'h1, 4'h1, 4'h0, 0, 0);

        // Bounded drain of the scoreboard
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d expected=0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
